crc16_share_arbiter: RTL
========================

CRC16_SHARE_ARBITER -- requirements
Module: crc16_share_arbiter

Parameters
REQ-001 TX_INI, 16'hFFFF, EngRegIni value driven for TX-path frames.
REQ-002 RX_INI, 16'hFFFF, EngRegIni value driven for RX-path frames.
REQ-003 MAX_WORDS, 256, maximum 32-bit words per frame; legal range 2..65535.
REQ-004 CHK_TMO, 8, maximum cycles DRAIN waits for EngCheckSync.
REQ-005 GAP, 2, idle cycles between frames; legal range 1..15.

Interface
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 RstN  in  1  asynchronous active-low reset.
REQ-008 TxVld/TxLast  in  1/1  TX requester word valid / last word of frame.
REQ-009 TxDin  in  32  TX requester word.
REQ-010 TxRdy  out  1  TX word accepted when TxVld&TxRdy.
REQ-011 RxVld/RxLast/RxDin/RxRdy  in/in/in/out  1/1/32/1  RX requester; same rules as the TX requester.
REQ-012 EngSyncIn/EngFlagTR  out  1/1  CRC engine frame sync / 1=TX check, 0=RX check.
REQ-013 EngRegIni  out  16  CRC engine LFSR initial value.
REQ-014 EngDinNd/EngDinLast  out  1/1  CRC engine word valid / last word.
REQ-015 EngDin/EngDinKeep  out  32/4  CRC engine word / keep (4'hF, except 4'hC on the last word).
REQ-016 EngCheckSync/EngCheckCRC  in  1/1  CRC engine check strobe / result (1 = CRC good).
REQ-017 GntTx/Busy  out  1/1  current grant is TX / a frame is in flight.
REQ-018 RxResVld/RxResOk/TxDone  out  1/1/1  one-cycle RX result strobe / RX CRC good / TX frame done strobe.
REQ-019 FrmLen  out  16  accepted word count of the last completed frame; valid with RxResVld or TxDone.
REQ-020 ErrUnderrun/ErrLen/ErrTmo  out  1/1/1  sticky error flags; cleared only by reset.

Function
REQ-021 FSM states: IDLE, SYNC, DATA, DRAIN, RESULT, GAP; every Eng* and status output SHALL be registered.
REQ-022 IDLE: when any Vld is high, grant one requester round-robin; if both are high, grant the one not granted last (TX after reset); latch GntTx; go to SYNC.
REQ-023 SYNC (1 cycle): EngSyncIn=1, EngFlagTR=GntTx, EngRegIni=TX_INI or RX_INI; both Rdy=0; Busy=1; go to DATA.
REQ-024 DATA: granted Rdy=1, other Rdy=0; each handshake drives, next cycle, EngDinNd=1 and EngDin=Din; the word counter increments.
REQ-025 EngDinNd SHALL be contiguous within a frame: the engine has no backpressure and detects the TX end on DinNd falling.
REQ-026 Frame end: a handshake with Last=1 sets EngDinLast on that word; Rdy drops the next cycle; go to DRAIN.
REQ-027 Underrun: granted Vld=0 in DATA after at least one accepted word sets ErrUnderrun; the previous word is treated as last (EngDinLast is not retro-asserted); go to DRAIN.
REQ-028 Vld=0 in DATA before any word is accepted: stay in DATA, no error.
REQ-029 Length: the MAX_WORDS-th accepted word is forced last; if its Last=0, ErrLen is set; go to DRAIN; the remaining requester words are not consumed by this frame.
REQ-030 DRAIN: EngDinNd=0; wait for EngCheckSync; on EngCheckSync go to RESULT; after CHK_TMO cycles without it, set ErrTmo and go to RESULT.
REQ-031 RESULT (1 cycle): sample EngCheckCRC; RX frame -> RxResVld=1, RxResOk=EngCheckCRC (0 if timed out); TX frame -> TxDone=1; FrmLen=word count.
REQ-032 GAP: hold GAP cycles with all Rdy=0; Busy=0 on the last GAP cycle; go to IDLE.
REQ-033 Word counter is 16-bit, cleared in SYNC, never wraps because REQ-029 caps it.
REQ-034 Simultaneous Vld on both requesters during a frame is ignored until IDLE; a non-granted requester is never starved beyond one frame.

Reset
REQ-035 RstN low asynchronously forces IDLE, round-robin pointer=RX-last (TX wins first), all outputs 0 including EngRegIni=16'h0000 and sticky errors.
REQ-036 Reset mid-frame abandons the frame without RxResVld/TxDone; the first frame after release SHALL start with SYNC.
REQ-037 Release of RstN is synchronised internally; first grant no earlier than 2 cycles after release.

Verification
REQ-038 Scenario: single RX frame of 4 words, valid CRC, engine model returns EngCheckCRC=1 -> one SYNC pulse, 4 contiguous EngDinNd, EngDinKeep=4'hC on word 4, RxResVld=1, RxResOk=1, FrmLen=4.
REQ-039 Scenario: TxVld and RxVld both high from reset, 3-word frames each -> TX granted first (EngFlagTR=1, TX_INI), then RX after GAP, TxDone then RxResVld, GntTx toggles.
REQ-040 Scenario: TxVld drops after word 2 of an intended 5 -> ErrUnderrun=1, EngDinLast on word 2 absent, TxDone with FrmLen=2.
REQ-041 Scenario: RX frame of MAX_WORDS+1 words with Last on the final word -> ErrLen=1, FrmLen=MAX_WORDS, RxRdy=0 during DRAIN.
REQ-042 Scenario: engine model never asserts EngCheckSync -> ErrTmo=1 after CHK_TMO cycles, RxResVld=1, RxResOk=0.
REQ-043 Scenario: RstN pulsed low mid-DATA -> all outputs 0 immediately, no result strobe, next frame starts with EngSyncIn.

Source files
------------

// File: rtl/crc16_share_arbiter.sv
// -----------------------------------------------------------------------------
// crc16_share_arbiter
//
// Shares one CRC16 check engine between a TX requester and an RX requester.
// Each requester presents 32-bit words with a valid/ready handshake. The
// arbiter grants one requester per frame and alternates when both want the
// engine. It sends a frame-sync pulse with the per-path LFSR seed, then
// streams the accepted words to the engine. It waits for the engine's check
// strobe and reports the result. Idle gap cycles separate frames.
//
// Ports
//   clk                  single clock, rising edge
//   RstN                 asynchronous active-low reset (release synchronised)
//   TxVld/TxLast/TxDin   TX requester word, valid, last-of-frame
//   TxRdy                TX word accepted when TxVld & TxRdy
//   RxVld/RxLast/RxDin   RX requester, same rules as TX
//   RxRdy                RX word accepted when RxVld & RxRdy
//   EngSyncIn            engine frame sync (one cycle)
//   EngFlagTR            1 = TX check, 0 = RX check
//   EngRegIni            engine LFSR seed
//   EngDinNd/EngDinLast  engine word valid / last word
//   EngDin/EngDinKeep    engine word / byte keep (F, C on last word)
//   EngCheckSync/CRC     engine result strobe / CRC good
//   GntTx/Busy           current grant is TX / frame in flight
//   RxResVld/RxResOk     RX result strobe / RX CRC good
//   TxDone               TX frame done strobe
//   FrmLen               accepted word count of the last completed frame
//   ErrUnderrun/ErrLen/ErrTmo  sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module crc16_share_arbiter #(
    parameter logic [15:0] TX_INI    = 16'hFFFF,
    parameter logic [15:0] RX_INI    = 16'hFFFF,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CHK_TMO   = 8,
    parameter int unsigned GAP       = 2
) (
    input  logic        clk,
    input  logic        RstN,
    input  logic        TxVld,
    input  logic        TxLast,
    input  logic [31:0] TxDin,
    output logic        TxRdy,
    input  logic        RxVld,
    input  logic        RxLast,
    input  logic [31:0] RxDin,
    output logic        RxRdy,
    output logic        EngSyncIn,
    output logic        EngFlagTR,
    output logic [15:0] EngRegIni,
    output logic        EngDinNd,
    output logic        EngDinLast,
    output logic [31:0] EngDin,
    output logic [3:0]  EngDinKeep,
    input  logic        EngCheckSync,
    input  logic        EngCheckCRC,
    output logic        GntTx,
    output logic        Busy,
    output logic        RxResVld,
    output logic        RxResOk,
    output logic        TxDone,
    output logic [15:0] FrmLen,
    output logic        ErrUnderrun,
    output logic        ErrLen,
    output logic        ErrTmo
);

    localparam logic [15:0] MAX_W     = 16'(MAX_WORDS);
    localparam logic [15:0] TMO_LAST  = 16'(CHK_TMO - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP - 1);
    localparam logic [3:0]  KEEP_FULL = 4'hF;
    localparam logic [3:0]  KEEP_LAST = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    // Byte keep for an engine word: the last word carries only the two CRC
    // bytes in its upper half.
    function automatic logic [3:0] word_keep(input logic is_last);
        return is_last ? KEEP_LAST : KEEP_FULL;
    endfunction

    logic [1:0]  rst_sync_q;
    logic        run;

    state_t      state_q, state_d;
    logic        gnt_tx_q, gnt_tx_d;
    logic        tx_rdy_q, tx_rdy_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic        eng_sync_in_q, eng_sync_in_d;
    logic        eng_flag_tr_q, eng_flag_tr_d;
    logic [15:0] eng_reg_ini_q, eng_reg_ini_d;
    logic        eng_din_nd_q, eng_din_nd_d;
    logic        eng_din_last_q, eng_din_last_d;
    logic [31:0] eng_din_q, eng_din_d;
    logic [3:0]  eng_din_keep_q, eng_din_keep_d;
    logic        busy_q, busy_d;
    logic        rx_res_vld_q, rx_res_vld_d;
    logic        rx_res_ok_q, rx_res_ok_d;
    logic        tx_done_q, tx_done_d;
    logic [15:0] frm_len_q, frm_len_d;
    logic        err_underrun_q, err_underrun_d;
    logic        err_len_q, err_len_d;
    logic        err_tmo_q, err_tmo_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;

    // Granted-requester view and per-word decode.
    logic        g_vld;
    logic        g_last;
    logic [31:0] g_din;
    logic        g_rdy;
    logic        hs;
    logic [15:0] word_inc;
    logic        force_last;
    logic        word_last;
    logic        pick_tx;
    logic        res_take;
    logic        res_ok;

    assign run        = rst_sync_q[1];
    assign g_vld      = gnt_tx_q ? TxVld  : RxVld;
    assign g_last     = gnt_tx_q ? TxLast : RxLast;
    assign g_din      = gnt_tx_q ? TxDin  : RxDin;
    assign g_rdy      = gnt_tx_q ? tx_rdy_q : rx_rdy_q;
    assign hs         = g_vld & g_rdy;
    assign word_inc   = word_cnt_q + 16'd1;
    assign force_last = (word_inc == MAX_W);
    assign word_last  = g_last | force_last;

    // Reset release synchroniser: assertion is asynchronous, while release
    // takes two clocks to reach the FSM enable.
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, so every output is a flop.
    always_comb begin
        state_d        = state_q;
        gnt_tx_d       = gnt_tx_q;
        tx_rdy_d       = tx_rdy_q;
        rx_rdy_d       = rx_rdy_q;
        eng_sync_in_d  = 1'b0;
        eng_flag_tr_d  = eng_flag_tr_q;
        eng_reg_ini_d  = eng_reg_ini_q;
        eng_din_nd_d   = 1'b0;
        eng_din_last_d = 1'b0;
        eng_din_d      = 32'h0000_0000;
        eng_din_keep_d = 4'h0;
        busy_d         = busy_q;
        rx_res_vld_d   = 1'b0;
        rx_res_ok_d    = rx_res_ok_q;
        tx_done_d      = 1'b0;
        frm_len_d      = frm_len_q;
        err_underrun_d = err_underrun_q;
        err_len_d      = err_len_q;
        err_tmo_d      = err_tmo_q;
        word_cnt_d     = word_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        pick_tx        = 1'b0;
        res_take       = 1'b0;
        res_ok         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_rdy_d = 1'b0;
                rx_rdy_d = 1'b0;
                // With both requesters pending, the one not granted last
                // wins. gnt_tx_q resets to 0, so TX wins first.
                pick_tx = TxVld & (~RxVld | ~gnt_tx_q);
                if (run && (TxVld || RxVld)) begin
                    gnt_tx_d      = pick_tx;
                    eng_sync_in_d = 1'b1;
                    eng_flag_tr_d = pick_tx;
                    eng_reg_ini_d = pick_tx ? TX_INI : RX_INI;
                    busy_d        = 1'b1;
                    state_d       = ST_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SYNC: begin
                word_cnt_d = 16'd0;
                tx_rdy_d   = gnt_tx_q;
                rx_rdy_d   = ~gnt_tx_q;
                state_d    = ST_DATA;
            end

            ST_DATA: begin
                if (hs) begin
                    eng_din_nd_d   = 1'b1;
                    eng_din_d      = g_din;
                    eng_din_last_d = word_last;
                    eng_din_keep_d = word_keep(word_last);
                    word_cnt_d     = word_inc;
                    // The counter cap ends the frame even without Last.
                    // The words the requester still holds stay unconsumed.
                    err_len_d      = err_len_q | (force_last & ~g_last);
                    if (word_last) begin
                        tx_rdy_d  = 1'b0;
                        rx_rdy_d  = 1'b0;
                        tmo_cnt_d = 16'd0;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (word_cnt_q != 16'd0) begin
                    // The requester stalled mid-frame. The engine has no
                    // backpressure, so the frame ends here. The engine sees
                    // the end as EngDinNd falling.
                    err_underrun_d = 1'b1;
                    tx_rdy_d       = 1'b0;
                    rx_rdy_d       = 1'b0;
                    tmo_cnt_d      = 16'd0;
                    state_d        = ST_DRAIN;
                end else begin
                    // No word has been accepted yet, so the wait is harmless.
                    state_d = ST_DATA;
                end
            end

            ST_DRAIN: begin
                if (EngCheckSync) begin
                    res_take = 1'b1;
                    res_ok   = EngCheckCRC;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    res_take  = 1'b1;
                    res_ok    = 1'b0;
                    err_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
                if (res_take) begin
                    rx_res_vld_d = ~gnt_tx_q;
                    tx_done_d    = gnt_tx_q;
                    rx_res_ok_d  = gnt_tx_q ? rx_res_ok_q : res_ok;
                    frm_len_d    = word_cnt_q;
                    state_d      = ST_RESULT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_RESULT: begin
                gap_cnt_d = 4'd0;
                // Busy drops on the final gap cycle. With a single gap cycle,
                // that is the first one.
                busy_d    = (GAP_LAST != 4'd0);
                state_d   = ST_GAP;
            end

            ST_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                    busy_d    = ((gap_cnt_q + 4'd1) != GAP_LAST);
                    state_d   = ST_GAP;
                end
            end

            default: begin
                tx_rdy_d = 1'b0;
                rx_rdy_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Single state/output register bank. Reset abandons any frame in flight
    // and clears every output, including the sticky error flags.
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            state_q        <= ST_IDLE;
            gnt_tx_q       <= 1'b0;
            tx_rdy_q       <= 1'b0;
            rx_rdy_q       <= 1'b0;
            eng_sync_in_q  <= 1'b0;
            eng_flag_tr_q  <= 1'b0;
            eng_reg_ini_q  <= 16'h0000;
            eng_din_nd_q   <= 1'b0;
            eng_din_last_q <= 1'b0;
            eng_din_q      <= 32'h0000_0000;
            eng_din_keep_q <= 4'h0;
            busy_q         <= 1'b0;
            rx_res_vld_q   <= 1'b0;
            rx_res_ok_q    <= 1'b0;
            tx_done_q      <= 1'b0;
            frm_len_q      <= 16'h0000;
            err_underrun_q <= 1'b0;
            err_len_q      <= 1'b0;
            err_tmo_q      <= 1'b0;
            word_cnt_q     <= 16'h0000;
            tmo_cnt_q      <= 16'h0000;
            gap_cnt_q      <= 4'h0;
        end else begin
            state_q        <= state_d;
            gnt_tx_q       <= gnt_tx_d;
            tx_rdy_q       <= tx_rdy_d;
            rx_rdy_q       <= rx_rdy_d;
            eng_sync_in_q  <= eng_sync_in_d;
            eng_flag_tr_q  <= eng_flag_tr_d;
            eng_reg_ini_q  <= eng_reg_ini_d;
            eng_din_nd_q   <= eng_din_nd_d;
            eng_din_last_q <= eng_din_last_d;
            eng_din_q      <= eng_din_d;
            eng_din_keep_q <= eng_din_keep_d;
            busy_q         <= busy_d;
            rx_res_vld_q   <= rx_res_vld_d;
            rx_res_ok_q    <= rx_res_ok_d;
            tx_done_q      <= tx_done_d;
            frm_len_q      <= frm_len_d;
            err_underrun_q <= err_underrun_d;
            err_len_q      <= err_len_d;
            err_tmo_q      <= err_tmo_d;
            word_cnt_q     <= word_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign TxRdy       = tx_rdy_q;
    assign RxRdy       = rx_rdy_q;
    assign EngSyncIn   = eng_sync_in_q;
    assign EngFlagTR   = eng_flag_tr_q;
    assign EngRegIni   = eng_reg_ini_q;
    assign EngDinNd    = eng_din_nd_q;
    assign EngDinLast  = eng_din_last_q;
    assign EngDin      = eng_din_q;
    assign EngDinKeep  = eng_din_keep_q;
    assign GntTx       = gnt_tx_q;
    assign Busy        = busy_q;
    assign RxResVld    = rx_res_vld_q;
    assign RxResOk     = rx_res_ok_q;
    assign TxDone      = tx_done_q;
    assign FrmLen      = frm_len_q;
    assign ErrUnderrun = err_underrun_q;
    assign ErrLen      = err_len_q;
    assign ErrTmo      = err_tmo_q;

endmodule
